// File: rtl/crossbar_sched_if.sv
// Request/grant bundle between the requesting agents and the crossbar scheduler.
// The master modport is the requester side, and the slave modport is the scheduler.
interface crossbar_sched_if;
    logic [2:0] req;
    logic [1:0] dest0;
    logic [1:0] dest1;
    logic [1:0] dest2;
    logic [2:0] grant;
    logic [5:0] select;
    logic [2:0] out_busy;
    logic       err;

    // Level handshake: req[i] is held with a stable dest until grant[i] rises.
    // The connection is kept while req[i] stays high, and dropping req[i] releases it.
    modport master (output req, dest0, dest1, dest2,
                    input  grant, select, out_busy, err);
    modport slave  (input  req, dest0, dest1, dest2,
                    output grant, select, out_busy, err);
endinterface

// File: rtl/crossbar_sched.sv
// Round-robin owner of the 3x3 crossbar select word. Each output arbitrates on its own,
// keeps its connection while the owner requests, and drives registered select and grant.
module crossbar_sched (
    input  logic             clk,
    input  logic             rst_n,
    crossbar_sched_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} out_state_e;

    out_state_e state_q [3];
    out_state_e state_d [3];
    logic [1:0] owner_q [3];
    logic [1:0] owner_d [3];
    logic [1:0] ptr_q   [3];
    logic [1:0] ptr_d   [3];
    logic [2:0] grant_q, grant_d;
    logic [5:0] select_q, select_d;
    logic       err_q, err_d;
    logic [1:0] dest [3];

    assign dest[0] = bus.dest0;
    assign dest[1] = bus.dest1;
    assign dest[2] = bus.dest2;

    function automatic logic [1:0] inc_mod3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    always_comb begin
        logic       found;
        logic       rel;
        logic [1:0] win;
        logic [1:0] idx;
        grant_d  = grant_q;
        select_d = select_q;
        err_d    = 1'b0;
        found    = 1'b0;
        rel      = 1'b0;
        win      = 2'd0;
        idx      = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (bus.req[i] && !grant_q[i] && dest[i] == 2'd3) err_d = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            owner_d[k] = owner_q[k];
            ptr_d[k]   = ptr_q[k];
            rel   = (state_q[k] == BUSY) && !bus.req[owner_q[k]];
            found = 1'b0;
            win   = 2'd0;
            idx   = ptr_q[k];
            // A granted requester is never a candidate, so a releasing owner cannot win again.
            for (int off = 0; off < 3; off++) begin
                if (!found && bus.req[idx] && !grant_q[idx] && dest[idx] == 2'(k)) begin
                    found = 1'b1;
                    win   = idx;
                end
                idx = inc_mod3(idx);
            end
            if (rel) begin
                state_d[k]        = IDLE;
                grant_d[owner_q[k]] = 1'b0;
                select_d[2*k +: 2] = 2'd3;
            end
            if ((state_q[k] == IDLE || rel) && found) begin
                state_d[k]         = BUSY;
                owner_d[k]         = win;
                ptr_d[k]           = inc_mod3(win);
                grant_d[win]       = 1'b1;
                select_d[2*k +: 2] = win;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= IDLE;
                owner_q[k] <= 2'd0;
                ptr_q[k]   <= 2'd0;
            end
            grant_q  <= 3'b000;
            select_q <= 6'h3F;
            err_q    <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= state_d[k];
                owner_q[k] <= owner_d[k];
                ptr_q[k]   <= ptr_d[k];
            end
            grant_q  <= grant_d;
            select_q <= select_d;
            err_q    <= err_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.select   = select_q;
    assign bus.out_busy = {state_q[2] == BUSY, state_q[1] == BUSY, state_q[0] == BUSY};
    assign bus.err      = err_q;
endmodule

// File: tb/tb_crossbar_sched.sv
// Directed bench for crossbar_sched. Expected {grant, select, out_busy, err} words are queued
// as stimulus is driven and compared after the following edge or immediately for async reset.
module tb_crossbar_sched;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [12:0] exp_q [$];
    logic [7:0]  din [3];

    crossbar_sched_if ifc ();

    crossbar_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] pk(input logic [2:0] g, input logic [5:0] s,
                                       input logic [2:0] b, input logic e);
        return {g, s, b, e};
    endfunction

    task automatic drive(input logic [2:0] r, input logic [1:0] d0,
                         input logic [1:0] d1, input logic [1:0] d2);
        ifc.req   = r;
        ifc.dest0 = d0;
        ifc.dest1 = d1;
        ifc.dest2 = d2;
    endtask

    task automatic check_pop(input string tag);
        logic [12:0] exp;
        logic [12:0] obs;
        exp = exp_q.pop_front();
        obs = {ifc.grant, ifc.select, ifc.out_busy, ifc.err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expectation for the outputs after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] g, input logic [5:0] s,
                       input logic [2:0] b, input logic e);
        exp_q.push_back(pk(g, s, b, e));
        @(posedge clk);
        #1;
        check_pop(tag);
    endtask

    task automatic now_chk(input string tag, input logic [2:0] g, input logic [5:0] s,
                           input logic [2:0] b, input logic e);
        exp_q.push_back(pk(g, s, b, e));
        check_pop(tag);
    endtask

    // Output 0 of the crossbar: the selected source byte, or zero when idle.
    task automatic check_xbar(input string tag, input int src);
        logic [1:0] sel;
        logic [7:0] obs;
        sel = ifc.select[1:0];
        obs = (sel == 2'd3) ? 8'h00 : din[sel];
        checks++;
        assert (obs === din[src]) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, din[src]);
        end
    endtask

    task automatic idle_gap();
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        repeat ($urandom_range(1, 3)) cyc("idle", 3'b000, 6'h3F, 3'b000, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) din[i] = 8'($urandom_range(0, 255));
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        @(posedge clk);
        #1;
        now_chk("reset_values", 3'b000, 6'h3F, 3'b000, 1'b0);
        rst_n = 1'b1;

        // Full permutation: out0<-1, out1<-2, out2<-0.
        drive(3'b111, 2'd2, 2'd0, 2'd1);
        cyc("perm_grant", 3'b111, 6'h09, 3'b111, 1'b0);
        drive(3'b000, 2'd2, 2'd0, 2'd1);
        cyc("perm_release", 3'b000, 6'h3F, 3'b000, 1'b0);

        // Asynchronous reset while connections are active.
        drive(3'b111, 2'd2, 2'd0, 2'd1);
        cyc("pre_reset_grant", 3'b111, 6'h09, 3'b111, 1'b0);
        rst_n = 1'b0;
        #1;
        now_chk("async_reset", 3'b000, 6'h3F, 3'b000, 1'b0);
        drive(3'b000, 2'd0, 2'd0, 2'd0);
        @(posedge clk);
        #1;
        now_chk("held_in_reset", 3'b000, 6'h3F, 3'b000, 1'b0);
        rst_n = 1'b1;

        // Three-way conflict on output 0, pointer rotates 0,1,2,0,1.
        drive(3'b111, 2'd0, 2'd0, 2'd0);
        cyc("rot_w0", 3'b001, 6'h3C, 3'b001, 1'b0);
        check_xbar("xbar_w0", 0);
        drive(3'b110, 2'd0, 2'd0, 2'd0);
        cyc("rot_w1", 3'b010, 6'h3D, 3'b001, 1'b0);
        check_xbar("xbar_w1", 1);
        drive(3'b101, 2'd0, 2'd0, 2'd0);
        cyc("rot_w2", 3'b100, 6'h3E, 3'b001, 1'b0);
        check_xbar("xbar_w2", 2);
        drive(3'b011, 2'd0, 2'd0, 2'd0);
        cyc("rot_wrap_w0", 3'b001, 6'h3C, 3'b001, 1'b0);
        check_xbar("xbar_wrap_w0", 0);
        drive(3'b110, 2'd0, 2'd0, 2'd0);
        cyc("rot_w1_again", 3'b010, 6'h3D, 3'b001, 1'b0);
        check_xbar("xbar_w1_again", 1);
        idle_gap();

        // Handover on output 1 from requester 0 to requester 2 with no idle cycle.
        drive(3'b001, 2'd1, 2'd0, 2'd0);
        cyc("ho_grant0", 3'b001, 6'h33, 3'b010, 1'b0);
        drive(3'b101, 2'd1, 2'd0, 2'd1);
        cyc("ho_wait2", 3'b001, 6'h33, 3'b010, 1'b0);
        drive(3'b100, 2'd1, 2'd0, 2'd1);
        cyc("ho_switch", 3'b100, 6'h3B, 3'b010, 1'b0);
        idle_gap();

        // Illegal destination holds err high each cycle and never wins.
        drive(3'b010, 2'd0, 2'd3, 2'd0);
        for (int n = 0; n < 4; n++) cyc("illegal_dest", 3'b000, 6'h3F, 3'b000, 1'b1);
        drive(3'b010, 2'd0, 2'd0, 2'd0);
        cyc("illegal_fixed", 3'b010, 6'h3D, 3'b001, 1'b0);
        idle_gap();

        // Dest changes while granted are ignored.
        drive(3'b001, 2'd2, 2'd0, 2'd0);
        cyc("dest_grant", 3'b001, 6'h0F, 3'b100, 1'b0);
        drive(3'b001, 2'd1, 2'd0, 2'd0);
        cyc("dest_change", 3'b001, 6'h0F, 3'b100, 1'b0);
        cyc("dest_change_hold", 3'b001, 6'h0F, 3'b100, 1'b0);
        drive(3'b000, 2'd1, 2'd0, 2'd0);
        cyc("dest_release", 3'b000, 6'h3F, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
